// File: rtl/alu_control_muldiv_pkg.sv
// Shared encodings for the ALU control decoder and the multiply/divide sequencer.
package alu_ctrl_pkg;

  // ALU select codes driven on alu_operation_o
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_NOR  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_NOP  = 4'b1001;
  localparam logic [3:0] ALU_MFHI = 4'b1010;
  localparam logic [3:0] ALU_MFLO = 4'b1011;

  // alu_op classes from main control
  localparam logic [2:0] AOP_MEM    = 3'b000;
  localparam logic [2:0] AOP_BRANCH = 3'b001;
  localparam logic [2:0] AOP_ORI    = 3'b010;
  localparam logic [2:0] AOP_ANDI   = 3'b011;
  localparam logic [2:0] AOP_ADDI   = 3'b100;
  localparam logic [2:0] AOP_LUI    = 3'b101;
  localparam logic [2:0] AOP_SLTI   = 3'b110;
  localparam logic [2:0] AOP_RTYPE  = 3'b111;

  // R-type funct field values
  localparam logic [5:0] FUNCT_SLL   = 6'b000000;
  localparam logic [5:0] FUNCT_SRL   = 6'b000010;
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } muldiv_op_e;

  // Map a multiply/divide funct onto the sequencer op; non-muldiv functs never reach it
  function automatic muldiv_op_e funct_to_op(input logic [5:0] funct);
    muldiv_op_e op;
    case (funct)
      FUNCT_MULT:  op = MD_MULT;
      FUNCT_MULTU: op = MD_MULTU;
      FUNCT_DIV:   op = MD_DIV;
      FUNCT_DIVU:  op = MD_DIVU;
      default:     op = MD_MULT;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_control_muldiv_iter.sv
// Iterative multiply/divide datapath: magnitude operands, one shift-add or
// restoring-subtract step per step pulse, sign correction presented on finish.
module muldiv_iter
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  input  logic                  finish,
  input  muldiv_op_e            op,
  input  logic [DATA_WIDTH-1:0] rs,
  input  logic [DATA_WIDTH-1:0] rt,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo,
  output logic                  div_zero
);

  localparam int W = DATA_WIDTH;

  function automatic logic [W-1:0] cond_neg(input logic [W-1:0] v, input logic neg);
    logic [W-1:0] r;
    if (neg) begin
      r = ~v + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r = v;
    end
    return r;
  endfunction

  muldiv_op_e     op_r;
  logic           neg_a_r;
  logic           neg_b_r;
  logic [W-1:0]   raw_rs_r;
  logic [W-1:0]   m_r;       // multiplicand (mult) or divisor (div) magnitude
  logic [W-1:0]   acc_hi_r;  // upper product half / partial remainder
  logic [W-1:0]   acc_lo_r;  // multiplier being shifted out / quotient shifted in

  logic           load_signed_s;
  logic           load_div_s;
  logic           sign_a_s;
  logic           sign_b_s;
  logic [W-1:0]   mag_a_s;
  logic [W-1:0]   mag_b_s;
  logic           is_div_s;
  logic [W:0]     sum_s;
  logic [W:0]     shifted_s;
  logic           ge_s;
  logic [W-1:0]   diff_s;
  logic [W-1:0]   next_hi_s;
  logic [W-1:0]   next_lo_s;
  logic [2*W-1:0] prod_s;

  // Operand magnitudes and signs for the op being loaded
  always_comb begin
    load_signed_s = (op == MD_MULT) || (op == MD_DIV);
    load_div_s    = (op == MD_DIV) || (op == MD_DIVU);
    sign_a_s      = load_signed_s & rs[W-1];
    sign_b_s      = load_signed_s & rt[W-1];
    mag_a_s       = cond_neg(rs, sign_a_s);
    mag_b_s       = cond_neg(rt, sign_b_s);
  end

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    is_div_s  = (op_r == MD_DIV) || (op_r == MD_DIVU);
    sum_s     = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, m_r} : {(W+1){1'b0}});
    shifted_s = {acc_hi_r, acc_lo_r[W-1]};
    ge_s      = (shifted_s >= {1'b0, m_r});
    // When ge_s the true difference is below m_r, so the low W bits are exact
    diff_s    = shifted_s[W-1:0] - m_r;
    if (is_div_s) begin
      next_hi_s = ge_s ? diff_s : shifted_s[W-1:0];
      next_lo_s = {acc_lo_r[W-2:0], ge_s};
    end else begin
      next_hi_s = sum_s[W:1];
      next_lo_s = {sum_s[0], acc_lo_r[W-1:1]};
    end
  end

  // Final result with sign correction and divide-by-zero override
  always_comb begin
    div_zero = is_div_s && (m_r == {W{1'b0}});
    prod_s   = {acc_hi_r, acc_lo_r};
    hi       = acc_hi_r;
    lo       = acc_lo_r;
    if (finish) begin
      if (!is_div_s) begin
        if (neg_a_r ^ neg_b_r) begin
          {hi, lo} = ~prod_s + {{(2*W-1){1'b0}}, 1'b1};
        end else begin
          {hi, lo} = prod_s;
        end
      end else if (div_zero) begin
        hi = raw_rs_r;
        lo = {W{1'b1}};
      end else begin
        // Remainder follows the dividend sign; the most-negative / -1 case
        // falls out naturally because negating 2^(W-1) wraps to itself
        hi = cond_neg(acc_hi_r, neg_a_r);
        lo = cond_neg(acc_lo_r, neg_a_r ^ neg_b_r);
      end
    end else begin
      hi = acc_hi_r;
      lo = acc_lo_r;
    end
  end

  // Operand capture on load, accumulator update on each step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r     <= MD_MULT;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      raw_rs_r <= {W{1'b0}};
      m_r      <= {W{1'b0}};
      acc_hi_r <= {W{1'b0}};
      acc_lo_r <= {W{1'b0}};
    end else if (load) begin
      op_r     <= op;
      neg_a_r  <= sign_a_s;
      neg_b_r  <= sign_b_s;
      raw_rs_r <= rs;
      acc_hi_r <= {W{1'b0}};
      if (load_div_s) begin
        m_r      <= mag_b_s;
        acc_lo_r <= mag_a_s;
      end else begin
        m_r      <= mag_a_s;
        acc_lo_r <= mag_b_s;
      end
    end else if (step) begin
      acc_hi_r <= next_hi_s;
      acc_lo_r <= next_lo_s;
    end else begin
      acc_hi_r <= acc_hi_r;
      acc_lo_r <= acc_lo_r;
    end
  end

endmodule

// File: rtl/alu_control_muldiv.sv
// Execute-stage ALU control: combinational select decode plus the MULT/DIV
// sequencer FSM that owns HI/LO and stalls the pipeline while iterating.
module alu_control_muldiv
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ALU_OP_WIDTH  = 3,
  parameter int ALU_SEL_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     valid_i,
  input  logic [ALU_OP_WIDTH-1:0]  alu_op_i,
  input  logic [5:0]               alu_function_i,
  input  logic [DATA_WIDTH-1:0]    rs_data_i,
  input  logic [DATA_WIDTH-1:0]    rt_data_i,
  output logic [ALU_SEL_WIDTH-1:0] alu_operation_o,
  output logic [DATA_WIDTH-1:0]    hi_o,
  output logic [DATA_WIDTH-1:0]    lo_o,
  output logic                     stall_o,
  output logic                     div_zero_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  state_e                  state_r;
  logic [CNT_W-1:0]        count_r;
  logic [DATA_WIDTH-1:0]   hi_r;
  logic [DATA_WIDTH-1:0]   lo_r;
  logic                    div_zero_r;

  logic [3:0]              sel_s;
  logic                    is_rtype_s;
  logic                    is_md_funct_s;
  logic                    start_s;
  logic                    mthi_s;
  logic                    mtlo_s;
  logic                    last_step_s;
  logic [DATA_WIDTH-1:0]   md_hi_s;
  logic [DATA_WIDTH-1:0]   md_lo_s;
  logic                    md_div_zero_s;

  // ALU select decode from op class and funct field
  always_comb begin
    sel_s = ALU_NOP;
    case (alu_op_i)
      ALU_OP_WIDTH'(AOP_MEM):    sel_s = ALU_ADD;
      ALU_OP_WIDTH'(AOP_BRANCH): sel_s = ALU_SUB;
      ALU_OP_WIDTH'(AOP_ORI):    sel_s = ALU_OR;
      ALU_OP_WIDTH'(AOP_ANDI):   sel_s = ALU_AND;
      ALU_OP_WIDTH'(AOP_ADDI):   sel_s = ALU_ADD;
      ALU_OP_WIDTH'(AOP_LUI):    sel_s = ALU_LUI;
      ALU_OP_WIDTH'(AOP_SLTI):   sel_s = ALU_SLT;
      ALU_OP_WIDTH'(AOP_RTYPE): begin
        case (alu_function_i)
          FUNCT_ADD, FUNCT_ADDU: sel_s = ALU_ADD;
          FUNCT_SUB:             sel_s = ALU_SUB;
          FUNCT_AND:             sel_s = ALU_AND;
          FUNCT_OR:              sel_s = ALU_OR;
          FUNCT_NOR:             sel_s = ALU_NOR;
          FUNCT_SLT:             sel_s = ALU_SLT;
          FUNCT_SLL:             sel_s = ALU_SLL;
          FUNCT_SRL:             sel_s = ALU_SRL;
          FUNCT_MFHI:            sel_s = ALU_MFHI;
          FUNCT_MFLO:            sel_s = ALU_MFLO;
          default:               sel_s = ALU_NOP;
        endcase
      end
      default: sel_s = ALU_NOP;
    endcase
  end

  assign alu_operation_o = ALU_SEL_WIDTH'(sel_s);

  // Instruction qualifiers for the sequencer and the HI/LO move instructions
  always_comb begin
    is_rtype_s    = (alu_op_i == ALU_OP_WIDTH'(AOP_RTYPE));
    is_md_funct_s = (alu_function_i == FUNCT_MULT) || (alu_function_i == FUNCT_MULTU) ||
                    (alu_function_i == FUNCT_DIV)  || (alu_function_i == FUNCT_DIVU);
    start_s       = valid_i && is_rtype_s && is_md_funct_s;
    mthi_s        = valid_i && is_rtype_s && (alu_function_i == FUNCT_MTHI);
    mtlo_s        = valid_i && is_rtype_s && (alu_function_i == FUNCT_MTLO);
    last_step_s   = (count_r == CNT_W'(DATA_WIDTH - 1));
  end

  // Stall covers the start cycle and every BUSY cycle; DONE lets the PC advance
  assign stall_o    = ((state_r == IDLE) && start_s) || (state_r == BUSY);
  assign hi_o       = hi_r;
  assign lo_o       = lo_r;
  assign div_zero_o = div_zero_r;

  muldiv_iter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     ((state_r == IDLE) && start_s),
    .step     (state_r == BUSY),
    .finish   (state_r == DONE),
    .op       (funct_to_op(alu_function_i)),
    .rs       (rs_data_i),
    .rt       (rt_data_i),
    .hi       (md_hi_s),
    .lo       (md_lo_s),
    .div_zero (md_div_zero_s)
  );

  // Sequencer FSM with step counter, HI/LO registers and divide-by-zero flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      count_r    <= {CNT_W{1'b0}};
      hi_r       <= {DATA_WIDTH{1'b0}};
      lo_r       <= {DATA_WIDTH{1'b0}};
      div_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          div_zero_r <= 1'b0;
          count_r    <= {CNT_W{1'b0}};
          if (start_s) begin
            state_r <= BUSY;
          end else if (mthi_s) begin
            hi_r <= rs_data_i;
          end else if (mtlo_s) begin
            lo_r <= rs_data_i;
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          count_r <= count_r + CNT_W'(1);
          if (last_step_s) begin
            state_r    <= DONE;
            div_zero_r <= md_div_zero_s;
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          // The instruction that started us is still presented here, so start is ignored
          hi_r       <= md_hi_s;
          lo_r       <= md_lo_s;
          div_zero_r <= 1'b0;
          count_r    <= {CNT_W{1'b0}};
          state_r    <= IDLE;
        end
        default: begin
          state_r    <= IDLE;
          count_r    <= {CNT_W{1'b0}};
          div_zero_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_muldiv.sv
// Self-checking bench for alu_control_muldiv: decode sweep, randomized
// MULT/DIV against an arithmetic reference model, HI/LO moves, mid-op reset.
module tb_alu_control_muldiv;

  logic        clk;
  logic        reset;
  logic        valid;
  logic [2:0]  alu_op;
  logic [5:0]  funct;
  logic [31:0] rs;
  logic [31:0] rt;
  logic [3:0]  sel;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall;
  logic        div_zero;

  int checks = 0;
  int errs   = 0;

  alu_control_muldiv #(
    .DATA_WIDTH(32),
    .ALU_OP_WIDTH(3),
    .ALU_SEL_WIDTH(4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .valid_i         (valid),
    .alu_op_i        (alu_op),
    .alu_function_i  (funct),
    .rs_data_i       (rs),
    .rt_data_i       (rt),
    .alu_operation_o (sel),
    .hi_o            (hi),
    .lo_o            (lo),
    .stall_o         (stall),
    .div_zero_o      (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference for MULT/MULTU/DIV/DIVU
  task automatic ref_md(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output int dz);
    int          sa;
    int          sb;
    logic [63:0] p;
    sa = a;
    sb = b;
    dz = 0;
    h  = 32'd0;
    l  = 32'd0;
    case (fn)
      6'b011000: begin
        p = longint'(sa) * longint'(sb);
        h = p[63:32];
        l = p[31:0];
      end
      6'b011001: begin
        p = {32'd0, a} * {32'd0, b};
        h = p[63:32];
        l = p[31:0];
      end
      6'b011010: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF; dz = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          h = 32'd0; l = 32'h8000_0000;
        end else begin
          l = sa / sb;
          h = sa % sb;
        end
      end
      default: begin
        if (b == 32'd0) begin
          h = a; l = 32'hFFFF_FFFF; dz = 1;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endtask

  // Run one MULT/DIV from IDLE, then read results back with MFHI/MFLO
  task automatic run_md(input string tag, input logic [5:0] fn, input logic [31:0] a,
                        input logic [31:0] b);
    logic [31:0] eh;
    logic [31:0] el;
    int          edz;
    int          stalls;
    int          dz_cycles;
    bit          done;
    ref_md(fn, a, b, eh, el, edz);
    valid  = 1'b1;
    alu_op = 3'b111;
    funct  = fn;
    rs     = a;
    rt     = b;
    stalls = 0;
    dz_cycles = 0;
    done   = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (stall) stalls++;
      else done = 1'b1;
      if (div_zero) dz_cycles++;
      @(posedge clk); #1;
      if (!done) begin
        rs = $urandom;
        rt = $urandom;
      end
    end
    #1;
    if (div_zero) dz_cycles++;
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_stalls"}, 64'(stalls), 64'd33);
    chk({tag, "_dz"}, 64'(dz_cycles), 64'(edz));
    funct = 6'b010000;
    rs    = $urandom;
    #1;
    chk({tag, "_mfhi_sel"}, 64'(sel), 64'(4'b1010));
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    @(posedge clk); #1;
    funct = 6'b010010;
    #1;
    chk({tag, "_mflo_sel"}, 64'(sel), 64'(4'b1011));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  logic [3:0] cls_sel [7] = '{4'b0011, 4'b0100, 4'b0001, 4'b0000, 4'b0011, 4'b1000, 4'b0111};
  logic [5:0] r_fn  [11] = '{6'b100000, 6'b100001, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                             6'b101010, 6'b000000, 6'b000010, 6'b010000, 6'b010010};
  logic [3:0] r_sel [11] = '{4'b0011, 4'b0011, 4'b0100, 4'b0000, 4'b0001, 4'b0010,
                             4'b0111, 4'b0101, 4'b0110, 4'b1010, 4'b1011};
  logic [5:0] nop_fn [5] = '{6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010001};

  initial begin
    logic [31:0] v;
    logic [5:0]  fn;
    logic [31:0] a;
    logic [31:0] b;
    reset  = 1'b1;
    valid  = 1'b0;
    alu_op = 3'b000;
    funct  = 6'd0;
    rs     = 32'd0;
    rt     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_dz", 64'(div_zero), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Decode sweep: op classes, listed functs, unlisted and muldiv/move functs
    valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      alu_op = 3'(i);
      funct  = 6'($urandom);
      #1;
      chk($sformatf("dec_cls%0d", i), 64'(sel), 64'(cls_sel[i]));
      chk($sformatf("dec_cls%0d_stall", i), 64'(stall), 64'd0);
      @(posedge clk); #1;
    end
    alu_op = 3'b111;
    for (int i = 0; i < 11; i++) begin
      funct = r_fn[i];
      #1;
      chk($sformatf("dec_fn%0d", i), 64'(sel), 64'(r_sel[i]));
      chk($sformatf("dec_fn%0d_stall", i), 64'(stall), 64'd0);
      @(posedge clk); #1;
    end
    funct = 6'b111111;
    #1;
    chk("dec_unlisted", 64'(sel), 64'(4'b1001));
    chk("dec_unlisted_stall", 64'(stall), 64'd0);
    valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      funct = nop_fn[i];
      #1;
      chk($sformatf("dec_nop%0d", i), 64'(sel), 64'(4'b1001));
      chk($sformatf("dec_nop%0d_stall", i), 64'(stall), 64'd0);
      @(posedge clk); #1;
    end

    // Directed MULT/DIV cases
    run_md("mult",   6'b011000, 32'hFFFF_FFFD, 32'd7);
    run_md("multu",  6'b011001, 32'hFFFF_FFFD, 32'd7);
    run_md("divu",   6'b011011, 32'd100, 32'd7);
    run_md("div",    6'b011010, 32'hFFFF_FFF9, 32'd2);
    run_md("divmin", 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
    run_md("divz",   6'b011011, 32'h0000_1234, 32'd0);
    run_md("divsz",  6'b011010, 32'hFFFF_8000, 32'd0);

    // Randomized MULT/DIV against the reference model
    for (int i = 0; i < 12; i++) begin
      fn = {4'b0110, 2'($urandom_range(0, 3))};
      a  = $urandom;
      if ($urandom_range(0, 3) == 0) a = 32'(-$urandom_range(1, 200));
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'(-$urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_md($sformatf("rnd%0d", i), fn, a, b);
    end

    // MTLO / MTHI then read back
    v      = 32'hA5A5_A5A5;
    valid  = 1'b1;
    alu_op = 3'b111;
    funct  = 6'b010011;
    rs     = v;
    #1;
    chk("mtlo_stall", 64'(stall), 64'd0);
    chk("mtlo_sel", 64'(sel), 64'(4'b1001));
    @(posedge clk); #1;
    funct = 6'b010010;
    rs    = 32'd0;
    #1;
    chk("mflo_sel", 64'(sel), 64'(4'b1011));
    chk("mtlo_lo", 64'(lo), 64'(v));
    @(posedge clk); #1;
    v     = $urandom;
    funct = 6'b010001;
    rs    = v;
    #1;
    chk("mthi_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    funct = 6'b010000;
    rs    = 32'd0;
    #1;
    chk("mfhi_sel", 64'(sel), 64'(4'b1010));
    chk("mthi_hi", 64'(hi), 64'(v));
    chk("mthi_lo_kept", 64'(lo), 64'(32'hA5A5_A5A5));
    @(posedge clk); #1;

    // Reset during BUSY cycle 10 of a MULT
    funct = 6'b011000;
    rs    = 32'hFFFF_FFFD;
    rt    = 32'd7;
    @(posedge clk); #1;
    repeat (9) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_stall", 64'(stall), 64'd1);
    valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_dz", 64'(div_zero), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_md("post_rst", 6'b011000, 32'hFFFF_FFFD, 32'd7);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/alu_control_muldiv.md
# alu_control_muldiv

Parametrised successor to the single-cycle ALU control decoder. It translates `alu_op_i`/`alu_function_i` into the ALU operation code for the full arithmetic/logic subset. It also owns an iterative multiply/divide sequencer with HI/LO registers and a stall output. It sits in the execute stage beside the ALU; `stall_o` freezes the PC and the register-file write enable while a MULT/DIV iterates.

## Interface
- `DATA_WIDTH`, default 32: operand and HI/LO width; iteration count equals `DATA_WIDTH`.
- `ALU_OP_WIDTH`, default 3: width of `alu_op_i`.
- `ALU_SEL_WIDTH`, default 4: width of `alu_operation_o`.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `valid_i` in 1: the instruction in execute is real (not a bubble).
- `alu_op_i` in `ALU_OP_WIDTH`: class from main control.
- `alu_function_i` in 6: R-type funct field.
- `rs_data_i` in `DATA_WIDTH`: dividend / multiplicand / MTHI-MTLO source.
- `rt_data_i` in `DATA_WIDTH`: divisor / multiplier.
- `alu_operation_o` out `ALU_SEL_WIDTH`: ALU select.
- `hi_o` out `DATA_WIDTH`: HI register.
- `lo_o` out `DATA_WIDTH`: LO register.
- `stall_o` out 1: hold PC and writeback.
- `div_zero_o` out 1: one-cycle flag, divide by zero completed.

## Operation
- **Decode (combinational, independent of FSM).**
  - `alu_op` classes: 000 (lw/sw) → ADD 0011; 001 (branch) → SUB 0100; 010 ORI → OR 0001; 011 ANDI → AND 0000; 100 ADDI → 0011; 101 LUI → 1000; 110 SLTI → SLT 0111; 111 R-type → funct.
  - R-type funct: 100000/100001 → 0011; 100010 → 0100; 100100 → 0000; 100101 → 0001; 100111 NOR → 0010; 101010 → 0111; 000000 SLL → 0101; 000010 SRL → 0110; 010000 MFHI → 1010; 010010 MFLO → 1011.
  - Anything else, including MULT/DIV/MTHI/MTLO → 1001 (no-op).
- **Start condition.** `valid_i` & R-type & funct in {011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU}.
- **FSM states IDLE, BUSY, DONE.**
  - IDLE + start: latch the operand magnitudes (absolute value for signed ops), the signs, and the op; clear the counter; go to BUSY.
  - BUSY: one shift-add (mult) or restoring-subtract (div) step per cycle; the counter increments; after `DATA_WIDTH` steps go to DONE.
  - DONE: at its closing edge, apply sign correction, load HI/LO, pulse `div_zero_o` if applicable, and go to IDLE. A start seen in DONE is ignored, because the same instruction is still presented.
- **`stall_o`.** Equals (IDLE & start) | BUSY. It is low in DONE so the PC advances at the DONE edge.
- **Mult result.** MULT/MULTU: {HI, LO} = 2·`DATA_WIDTH`-bit product. For signed ops the product is negated if the signs differ.
- **Div result.** DIV/DIVU: LO = quotient, HI = remainder.
  - Signed: quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Most-negative ÷ −1: LO = most-negative, HI = 0.
- **Divide by zero (both kinds).** LO = all ones, HI = `rs_data_i` (raw); `div_zero_o` = 1 during the DONE cycle.
- **MTHI/MTLO** (funct 010001/010011). With `valid_i` in IDLE, HI (resp. LO) is loaded from `rs_data_i` at the next edge; no stall.
- **Operand stability.** Operand and `valid_i` changes during BUSY/DONE are ignored; the latched values are used.

## Timing
- **Reset values.** On async reset, at any time including mid-BUSY: state IDLE, counter 0, HI = LO = 0, `stall_o` = 0 (once `valid_i`/start are also low), `div_zero_o` = 0. `alu_operation_o` is combinational and is not reset.
- **MULT/DIV cycle count.** The instruction occupies `DATA_WIDTH` + 2 cycles:
  - Cycle 0: start, stall.
  - Cycles 1..`DATA_WIDTH`: BUSY, stall.
  - Cycle `DATA_WIDTH`+1: DONE, no stall.
- **Result visibility.** HI/LO are valid from cycle `DATA_WIDTH` + 2, so an MFHI immediately following reads the new value.
- **No back-to-back overlap.** A second MULT after DONE starts cleanly in IDLE.

## Structure
- **Package `alu_ctrl_pkg`:**
  - ALU select codes (0000–1011).
  - `alu_op` class encodings.
  - Funct constants.
  - FSM state enum {IDLE, BUSY, DONE}.
  - Muldiv op enum {MULT, MULTU, DIV, DIVU}.
- **Sub-module `muldiv_iter`.** Datapath only: magnitude registers, partial product/remainder, one step per `step_i`, sign fix on `finish_i`. The top level holds the decode, FSM, counter, HI/LO and flags.

## Test plan
- **Decode sweep.** Every `alu_op` class and listed funct with `valid_i` = 1 → exact select codes above; unlisted funct 111111 → 1001; `stall_o` = 0 throughout.
- **MULT.** rs = 0xFFFFFFFD (−3), rt = 7 → `stall_o` high for 33 cycles, low in the DONE cycle; afterwards HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. MULTU on the same operands → HI = 0x00000006, LO = 0xFFFFFFEB.
- **DIVU and DIV.**
  - DIVU rs = 100, rt = 7 → LO = 14, HI = 2.
  - DIV rs = −7, rt = 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIV 0x80000000 ÷ 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Divide by zero.** DIVU rs = 0x1234, rt = 0 → LO = 0xFFFFFFFF, HI = 0x1234; `div_zero_o` high exactly one cycle.
- **MTHI/MTLO then MFHI.** MTLO 0xA5A5A5A5 → LO updated at the next edge, no stall; a following MFLO selects 1011 and `lo_o` = 0xA5A5A5A5.
- **Reset mid-operation.** Assert `reset` at BUSY cycle 10 of a MULT → state IDLE, HI = LO = 0, `stall_o` low immediately. A new MULT after release completes in the normal `DATA_WIDTH` + 2 cycles with correct results.
